// File: rtl/sseg_display_driver.sv
// Two-digit seven-segment driver: converts a 7-bit binary count to BCD with a
// sequential double-dabble and latches active-low segment patterns on completion.
module sseg_display_driver #(
  parameter int LEADING_ZERO_BLANK = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [6:0] i_Value,
  input  logic       i_Load,
  output logic       o_Busy,
  output logic       o_Done,
  output logic [6:0] o_Seg1,
  output logic [6:0] o_Seg2
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  state_t     r_State;
  state_t     w_NextState;
  logic [6:0] r_Bin;
  logic [9:0] r_Bcd;
  logic [2:0] r_Step;
  logic [3:0] w_OnesAdj;
  logic [3:0] w_TensAdj;
  logic       w_Overflow;
  logic [6:0] w_Seg1;
  logic [6:0] w_Seg2;

  function automatic logic [6:0] f_Decode(input logic [3:0] i_Digit);
    logic [6:0] v_Seg;
    case (i_Digit)
      4'd0:    v_Seg = 7'b0000001;
      4'd1:    v_Seg = 7'b1001111;
      4'd2:    v_Seg = 7'b0010010;
      4'd3:    v_Seg = 7'b0000110;
      4'd4:    v_Seg = 7'b1001100;
      4'd5:    v_Seg = 7'b0100100;
      4'd6:    v_Seg = 7'b0100000;
      4'd7:    v_Seg = 7'b0001111;
      4'd8:    v_Seg = 7'b0000000;
      4'd9:    v_Seg = 7'b0000100;
      default: v_Seg = SEG_BLANK;
    endcase
    return v_Seg;
  endfunction

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= IDLE;
    else       r_State <= w_NextState;
  end

  always_comb begin
    w_NextState = r_State;
    case (r_State)
      IDLE:    if (i_Load) w_NextState = SHIFT;
      SHIFT:   if (r_Step == 3'd6) w_NextState = UPDATE;
      UPDATE:  w_NextState = IDLE;
      default: w_NextState = IDLE;
    endcase
  end

  // Hundreds never exceeds 1 for a 7-bit input, so only tens/ones need the +3 correction.
  always_comb begin
    w_OnesAdj  = (r_Bcd[3:0] >= 4'd5) ? r_Bcd[3:0] + 4'd3 : r_Bcd[3:0];
    w_TensAdj  = (r_Bcd[7:4] >= 4'd5) ? r_Bcd[7:4] + 4'd3 : r_Bcd[7:4];
    w_Overflow = (r_Bcd[9:8] != 2'd0);
    w_Seg2     = w_Overflow ? SEG_DASH : f_Decode(r_Bcd[3:0]);
    if (w_Overflow)
      w_Seg1 = SEG_DASH;
    else if ((r_Bcd[7:4] == 4'd0) && (LEADING_ZERO_BLANK != 0))
      w_Seg1 = SEG_BLANK;
    else
      w_Seg1 = f_Decode(r_Bcd[7:4]);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Bin  <= 7'd0;
      r_Bcd  <= 10'd0;
      r_Step <= 3'd0;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
      o_Seg1 <= SEG_BLANK;
      o_Seg2 <= SEG_BLANK;
    end else begin
      o_Done <= 1'b0;
      case (r_State)
        IDLE: begin
          if (i_Load) begin
            r_Bin  <= i_Value;
            r_Bcd  <= 10'd0;
            r_Step <= 3'd0;
            o_Busy <= 1'b1;
          end
        end
        SHIFT: begin
          r_Bcd  <= {r_Bcd[8], w_TensAdj, w_OnesAdj, r_Bin[6]};
          r_Bin  <= {r_Bin[5:0], 1'b0};
          r_Step <= r_Step + 3'd1;
        end
        UPDATE: begin
          o_Seg1 <= w_Seg1;
          o_Seg2 <= w_Seg2;
          o_Done <= 1'b1;
          o_Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_display_driver.sv
// Scoreboard bench for sseg_display_driver: two instances (leading-zero blanking
// on and off) share stimulus; expected segment pairs are queued and popped on o_Done.
module tb_sseg_display_driver;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [6:0] i_Value;
  logic       i_Load;
  logic       o_Busy,  o_Done;
  logic [6:0] o_Seg1,  o_Seg2;
  logic       o_BusyN, o_DoneN;
  logic [6:0] o_Seg1N, o_Seg2N;

  int compares    = 0;
  int miscompares = 0;
  int pushCount   = 0;
  int doneCount   = 0;
  int doneCountN  = 0;

  logic [13:0] qBlank[$];
  logic [13:0] qNoBlank[$];

  sseg_display_driver #(.LEADING_ZERO_BLANK(1)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Value(i_Value), .i_Load(i_Load),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Seg1(o_Seg1), .o_Seg2(o_Seg2)
  );

  sseg_display_driver #(.LEADING_ZERO_BLANK(0)) dutNoBlank (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Value(i_Value), .i_Load(i_Load),
    .o_Busy(o_BusyN), .o_Done(o_DoneN), .o_Seg1(o_Seg1N), .o_Seg2(o_Seg2N)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference model from the digit table, used for the sweep.
  function automatic logic [6:0] refDigit(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [13:0] refPair(input int v, input bit blank);
    if (v > 99) return {7'b1111110, 7'b1111110};
    if ((v / 10 == 0) && blank) return {7'b1111111, refDigit(v % 10)};
    return {refDigit(v / 10), refDigit(v % 10)};
  endfunction

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic applyStimulus(input logic [6:0] v, input logic [6:0] e1, input logic [6:0] e2,
                               input logic [6:0] e1NoBlank);
    int busyCycles;
    i_Value = v;
    i_Load  = 1'b1;
    qBlank.push_back({e1, e2});
    qNoBlank.push_back({e1NoBlank, e2});
    pushCount++;
    @(posedge i_Clk);
    #1 i_Load = 1'b0;
    busyCycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_Clk);
      if (o_Busy) busyCycles++;
      else break;
    end
    checkOutput($sformatf("busy_cycles_%0d", v), 14'(busyCycles), 14'd8);
  endtask

  always @(negedge i_Clk) begin
    if (o_Done) begin
      doneCount++;
      compares++;
      if (qBlank.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_done: got pulse with segs %b_%b, expected none", o_Seg1, o_Seg2);
      end else begin
        compares--;
        checkOutput("segs_blank", {o_Seg1, o_Seg2}, qBlank.pop_front());
        checkOutput("busy_at_done", {13'd0, o_Busy}, 14'd0);
      end
    end
  end

  always @(negedge i_Clk) begin
    if (o_DoneN) begin
      doneCountN++;
      compares++;
      if (qNoBlank.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_done_noblank: got pulse with segs %b_%b, expected none", o_Seg1N, o_Seg2N);
      end else begin
        compares--;
        checkOutput("segs_noblank", {o_Seg1N, o_Seg2N}, qNoBlank.pop_front());
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_segs"},      {o_Seg1, o_Seg2},   {7'b1111111, 7'b1111111});
    checkOutput({tag, "_segs_nb"},   {o_Seg1N, o_Seg2N}, {7'b1111111, 7'b1111111});
    checkOutput({tag, "_busy_done"}, {12'd0, o_Busy, o_Done}, 14'd0);
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_Load  = 1'b0;
    i_Value = 7'd0;
    repeat (3) @(negedge i_Clk);
    checkResetState("reset");
    i_Rst = 1'b0;
    @(negedge i_Clk);

    applyStimulus(7'd42, 7'b1001100, 7'b0010010, 7'b1001100);
    applyStimulus(7'd7,  7'b1111111, 7'b0001111, 7'b0000001);
    applyStimulus(7'd0,  7'b1111111, 7'b0000001, 7'b0000001);
    applyStimulus(7'd99, 7'b0000100, 7'b0000100, 7'b0000100);
    applyStimulus(7'd100, 7'b1111110, 7'b1111110, 7'b1111110);
    applyStimulus(7'd127, 7'b1111110, 7'b1111110, 7'b1111110);

    // 55 with stray loads of 12 at E3 and E8; only 55 may appear.
    repeat (2) @(negedge i_Clk);
    i_Value = 7'd55;
    i_Load  = 1'b1;
    qBlank.push_back({7'b0100100, 7'b0100100});
    qNoBlank.push_back({7'b0100100, 7'b0100100});
    pushCount++;
    @(posedge i_Clk);
    #1 i_Load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge i_Clk);
      if (i == 3 || i == 8) begin
        i_Value = 7'd12;
        i_Load  = 1'b1;
      end else begin
        i_Load  = 1'b0;
      end
    end
    @(negedge i_Clk);
    i_Load = 1'b0;
    checkOutput("busy_after_ignored_e8", {13'd0, o_Busy}, 14'd0);
    repeat (10) @(negedge i_Clk);
    checkOutput("hold_55", {o_Seg1, o_Seg2}, {7'b0100100, 7'b0100100});

    // 88 aborted by reset at E4, held two cycles.
    i_Value = 7'd88;
    i_Load  = 1'b1;
    @(posedge i_Clk);
    #1 i_Load = 1'b0;
    repeat (4) @(posedge i_Clk);
    #1 i_Rst = 1'b1;
    #1 checkResetState("abort");
    repeat (2) @(negedge i_Clk);
    checkResetState("abort_hold");
    i_Rst = 1'b0;
    repeat (12) @(negedge i_Clk);
    checkResetState("post_abort");
    applyStimulus(7'd31, 7'b0000110, 7'b1001111, 7'b0000110);

    for (int v = 0; v < 128; v++) begin
      logic [13:0] pb, pn;
      pb = refPair(v, 1'b1);
      pn = refPair(v, 1'b0);
      applyStimulus(7'(v), pb[13:7], pb[6:0], pn[13:7]);
    end

    repeat (5) @(negedge i_Clk);
    checkOutput("queue_drained",    14'(qBlank.size()),   14'd0);
    checkOutput("queue_drained_nb", 14'(qNoBlank.size()), 14'd0);
    checkOutput("done_pulses",      14'(doneCount),       14'(pushCount));
    checkOutput("done_pulses_nb",   14'(doneCountN),      14'(pushCount));

    $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_display_driver.md
SSEG_DISPLAY_DRIVER -- requirements
Module: sseg_display_driver

Interface
REQ-001 Parameter LEADING_ZERO_BLANK, default 1: when 1, a zero tens digit is blanked.
REQ-002 i_Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_Rst  input  1  reset, asynchronous and active-high.
REQ-004 i_Value  input  7  unsigned binary count to display, 0..127.
REQ-005 i_Load  input  1  request to convert and display i_Value; sampled each rising edge.
REQ-006 o_Busy  output  1  high while a conversion is in progress; new loads are ignored.
REQ-007 o_Done  output  1  one-cycle pulse on the edge the segment outputs update.
REQ-008 o_Seg1  output  7  tens digit, bit6..bit0 = segments A..G, active-low (0 = lit).
REQ-009 o_Seg2  output  7  ones digit, same encoding as o_Seg1.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, UPDATE.
REQ-011 In IDLE, an edge with i_Load=1 SHALL capture i_Value, clear the BCD accumulator, zero the step counter, set o_Busy=1 and enter SHIFT (acceptance edge, E0).
REQ-012 In IDLE with i_Load=0 the block SHALL hold all outputs unchanged.
REQ-013 In SHIFT, each edge SHALL perform one double-dabble step: add 3 to each BCD nibble >= 5, then shift {BCD, binary} left by one.
REQ-014 SHIFT SHALL last exactly 7 edges (E1..E7); after E7 the FSM SHALL be in UPDATE.
REQ-015 In UPDATE (edge E8), o_Seg1/o_Seg2 SHALL load the new patterns, o_Done SHALL pulse high, o_Busy SHALL return to 0 and the FSM SHALL return to IDLE.
REQ-016 Load-to-display latency SHALL be 8 clock edges after E0; o_Busy SHALL be high for exactly 8 cycles.
REQ-017 i_Load asserted while o_Busy=1 SHALL be ignored without effect on the conversion in progress.
REQ-018 i_Load asserted on the same edge o_Busy falls (E8) SHALL be ignored; a load is accepted only when sampled in IDLE.
REQ-019 Digit patterns (active-high A..G, outputs are the bitwise inverse): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-020 Values 0..99 SHALL display tens on o_Seg1 and ones on o_Seg2.
REQ-021 Values 100..127 (overflow) SHALL display a dash (only G lit, o_Seg = 7'b1111110) on both digits.
REQ-022 With LEADING_ZERO_BLANK=1 and tens=0, o_Seg1 SHALL be 7'b1111111 (all off); ones digit is never blanked, so 0 shows as a single "0".
REQ-023 With LEADING_ZERO_BLANK=0, a zero tens digit SHALL display as "0".
REQ-024 Segment outputs SHALL be registered, glitch-free, and change only on the UPDATE edge.
REQ-025 o_Done SHALL be 0 at all times other than the single UPDATE cycle.

Reset
REQ-026 While i_Rst=1: o_Seg1=o_Seg2=7'b1111111, o_Busy=0, o_Done=0, FSM=IDLE, accumulators cleared.
REQ-027 Reset asserted mid-conversion SHALL abort it immediately; no UPDATE and no o_Done pulse occur for the aborted load.
REQ-028 After i_Rst deasserts, the first i_Load sampled high in IDLE SHALL be accepted normally.

Verification
REQ-029 Reset then i_Value=42, i_Load pulse -> o_Busy high 8 cycles; at E8 o_Done=1, o_Seg1=7'b1001100 ("4"), o_Seg2=7'b0010010 ("2").
REQ-030 i_Value=7 and i_Value=0 with LEADING_ZERO_BLANK=1 -> o_Seg1=7'b1111111; o_Seg2=7'b0001111 / 7'b0000001; repeat with parameter 0 -> o_Seg1=7'b0000001.
REQ-031 i_Value=99, then 100, then 127 -> "99" (both 7'b0000100), then dashes (both 7'b1111110) twice.
REQ-032 Load 55, assert i_Load with i_Value=12 at E3 and at E8 -> both ignored; display "55" (both 7'b0100100), one o_Done pulse only.
REQ-033 Load 88, assert i_Rst at E4 for 2 cycles -> outputs all 7'b1111111, o_Busy=0, no o_Done; subsequent load of 31 displays "31" after 8 cycles.
REQ-034 Sweep i_Value 0..127 back-to-back (load on each IDLE cycle) -> every result matches the REQ-019..REQ-022 reference model.
